// File: rtl/instruction_memory.sv
// Word-addressed instruction memory with a clear-after-reset pass and a valid/ready
// program-load port; combinational read for a single-cycle datapath.
module instruction_memory #(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           PC,
  output logic [31:0]           instr,
  output logic                  fault,
  output logic                  run,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [31:0]           load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic [DEPTH_LOG2:0]   load_count
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  localparam logic [1:0] StClear = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StLoad  = 2'd2;

  localparam logic [DEPTH_LOG2-1:0] LastAddr   = DEPTH_LOG2'(Depth - 1);
  localparam logic [DEPTH_LOG2:0]   CountLimit = (DEPTH_LOG2 + 1)'(Depth);

  logic [31:0]           mem [Depth];
  logic [1:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_addr_q, clr_addr_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2:0]   load_count_q, load_count_d;

  logic                  accept;
  logic                  pc_ok;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  assign accept = (state_q == StLoad) && load_valid;
  assign pc_ok  = (PC[1:0] == 2'b00) && (PC[31:DEPTH_LOG2+2] == '0);

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    wptr_d       = wptr_q;
    load_count_d = load_count_q;
    mem_we       = 1'b0;
    mem_waddr    = clr_addr_q;
    mem_wdata    = 32'h0;
    case (state_q)
      StClear: begin
        mem_we     = 1'b1;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LastAddr) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (load_start) begin
          state_d      = StLoad;
          wptr_d       = '0;
          load_count_d = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          mem_we    = 1'b1;
          mem_waddr = wptr_q;
          mem_wdata = load_data;
          wptr_d    = wptr_q + 1'b1;
          if (load_count_q != CountLimit) begin
            load_count_d = load_count_q + 1'b1;
          end
          if (load_last || (wptr_q == LastAddr)) begin
            state_d = StRun;
          end
        end
      end
      default: begin
        state_d    = StClear;
        clr_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StClear;
      clr_addr_q   <= '0;
      wptr_q       <= '0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      wptr_q       <= wptr_d;
      load_count_q <= load_count_d;
    end
  end

  // Array is not reset; the clear pass that follows reset zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    instr = 32'h0;
    fault = 1'b0;
    if (state_q == StRun) begin
      if (pc_ok) begin
        instr = mem[PC[DEPTH_LOG2+1:2]];
      end else begin
        fault = 1'b1;
      end
    end
  end

  assign run        = (state_q == StRun);
  assign load_ready = (state_q == StLoad);
  assign load_count = load_count_q;

endmodule
